login_control: RTL and testbench

//  Login/password front end that drives the game controller's login handshake.
//  - Collects keypad digits and compares them with a stored password.
//  - Raises Log_In to admit the player.
//  - Consumes the controller's Log_Out and Pwd_Res pulses to end the session
//    or to program a new password.
//  - Enforces a bounded number of attempts, with a timed lockout.

---
 rtl/login_control_pkg.sv | 38 +++
 rtl/login_control_digit_entry_buf.sv | 37 +++
 rtl/login_control.sv | 128 ++++++++++++
 tb/tb_login_control.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/login_control_pkg.sv
// Shared constants, state encoding and digit helpers
// for the login/password front end.
package login_control_pkg;

   localparam int PWD_DIGITS  = 4;
   localparam int DIGIT_W     = 4;
   localparam int PWD_W       = PWD_DIGITS * DIGIT_W;
   localparam int MAX_TRIES   = 3;
   localparam int LOCK_CYCLES = 100;

   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int CNT_W  = $clog2(PWD_DIGITS + 1);
   localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

   localparam logic [PWD_W-1:0] DEFAULT_PWD = 16'h1234;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      GRANTED,
      NEWPWD,
      LOCKOUT
   } login_state_t;

   function automatic logic bcd_valid(
      input logic [DIGIT_W-1:0] d
   );
      return d <= DIGIT_W'(9);
   endfunction

   function automatic logic [PWD_W-1:0] shift_in(
      input logic [PWD_W-1:0]   b,
      input logic [DIGIT_W-1:0] d
   );
      return {b[PWD_W-DIGIT_W-1:0], d};
   endfunction

endpackage

// File: rtl/login_control_digit_entry_buf.sv
// Keypad shift buffer and digit counter; Done fires on
// the edge that accepts the last digit of a full entry.
module login_control_digit_entry_buf
   import login_control_pkg::*;
(
   input  logic               Clk,
   input  logic               Rst,
   input  logic               En,
   input  logic               Enter_Pls,
   input  logic               Clr_Pls,
   input  logic [DIGIT_W-1:0] Digit_In,
   output logic [PWD_W-1:0]   Entry,
   output logic [CNT_W-1:0]   Digit_Cnt,
   output logic               Done
);

   logic accept;

   assign accept = En && Enter_Pls && !Clr_Pls
                && bcd_valid(Digit_In);
   assign Done   = accept
                && (Digit_Cnt == CNT_W'(PWD_DIGITS - 1));

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         Entry     <= '0;
         Digit_Cnt <= '0;
      end else if (En && Clr_Pls) begin
         Entry     <= '0;
         Digit_Cnt <= '0;
      end else if (accept) begin
         Entry     <= shift_in(Entry, Digit_In);
         Digit_Cnt <= Done ? '0 : Digit_Cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/login_control.sv
// Login FSM: password check, attempt limit with timed
// lockout, and password change on controller request.
module login_control
   import login_control_pkg::*;
(
   input  logic               Clk,
   input  logic               Rst,
   input  logic [DIGIT_W-1:0] Digit_In,
   input  logic               Enter_Pls,
   input  logic               Clr_Pls,
   input  logic               Log_Out,
   input  logic               Pwd_Res,
   output logic               Log_In,
   output logic               Pwd_Mode,
   output logic               Locked,
   output logic               Err_Pls,
   output logic [TRY_W-1:0]   Tries_Left,
   output logic [CNT_W-1:0]   Digit_Cnt
);

   login_state_t      state, state_n;
   logic [PWD_W-1:0]  pwd, pwd_n, entry;
   logic [LOCK_W-1:0] lock_cnt, lock_n;
   logic [TRY_W-1:0]  tries_n;
   logic              log_in_n, pwd_mode_n;
   logic              locked_n, err_n;
   logic              entry_en, done;

   assign entry_en = (state == IDLE)
                  || (state == NEWPWD);

   login_control_digit_entry_buf u_entry (
      .Clk       (Clk),
      .Rst       (Rst),
      .En        (entry_en),
      .Enter_Pls (Enter_Pls),
      .Clr_Pls   (Clr_Pls),
      .Digit_In  (Digit_In),
      .Entry     (entry),
      .Digit_Cnt (Digit_Cnt),
      .Done      (done)
   );

   always_comb begin
      state_n    = state;
      pwd_n      = pwd;
      lock_n     = lock_cnt;
      tries_n    = Tries_Left;
      log_in_n   = Log_In;
      pwd_mode_n = Pwd_Mode;
      locked_n   = Locked;
      err_n      = 1'b0;
      unique case (state)
         IDLE: begin
            if (done) state_n = CHECK;
         end
         CHECK: begin
            if (entry == pwd) begin
               state_n  = GRANTED;
               log_in_n = 1'b1;
               tries_n  = TRY_W'(MAX_TRIES);
            end else begin
               err_n   = 1'b1;
               tries_n = Tries_Left - TRY_W'(1);
               if (Tries_Left == TRY_W'(1)) begin
                  state_n  = LOCKOUT;
                  locked_n = 1'b1;
                  lock_n   = LOCK_W'(LOCK_CYCLES - 1);
               end else begin
                  state_n = IDLE;
               end
            end
         end
         GRANTED: begin
            if (Log_Out) begin
               log_in_n = 1'b0;
               if (Pwd_Res) begin
                  state_n    = NEWPWD;
                  pwd_mode_n = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         NEWPWD: begin
            // last digit is still on Digit_In, not yet in entry
            if (done) begin
               pwd_n      = shift_in(entry, Digit_In);
               pwd_mode_n = 1'b0;
               state_n    = IDLE;
            end
         end
         LOCKOUT: begin
            if (lock_cnt == '0) begin
               state_n  = IDLE;
               locked_n = 1'b0;
               tries_n  = TRY_W'(MAX_TRIES);
            end else begin
               lock_n = lock_cnt - LOCK_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= IDLE;
         pwd        <= DEFAULT_PWD;
         lock_cnt   <= '0;
         Tries_Left <= TRY_W'(MAX_TRIES);
         Log_In     <= 1'b0;
         Pwd_Mode   <= 1'b0;
         Locked     <= 1'b0;
         Err_Pls    <= 1'b0;
      end else begin
         state      <= state_n;
         pwd        <= pwd_n;
         lock_cnt   <= lock_n;
         Tries_Left <= tries_n;
         Log_In     <= log_in_n;
         Pwd_Mode   <= pwd_mode_n;
         Locked     <= locked_n;
         Err_Pls    <= err_n;
      end
   end

endmodule

// File: tb/tb_login_control.sv
// Directed bench for login_control with a session-level
// reference model checked every cycle.
module tb_login_control;

   logic       clk;
   logic       rst_n;
   logic [3:0] digit;
   logic       enter, clr, log_out, pwd_res;
   logic       log_in, pwd_mode, locked, err_pls;
   logic [1:0] tries;
   logic [2:0] dcnt;

   int n_vec = 0;
   int n_bad = 0;

   login_control dut (
      .Clk        (clk),
      .Rst        (rst_n),
      .Digit_In   (digit),
      .Enter_Pls  (enter),
      .Clr_Pls    (clr),
      .Log_Out    (log_out),
      .Pwd_Res    (pwd_res),
      .Log_In     (log_in),
      .Pwd_Mode   (pwd_mode),
      .Locked     (locked),
      .Err_Pls    (err_pls),
      .Tries_Left (tries),
      .Digit_Cnt  (dcnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   // session-level model: digits held in a queue,
   // password as a digit array, lockout as cycles left
   bit m_login = 0, m_pmode = 0, m_locked = 0, m_err = 0;
   int m_tries = 3, m_cnt = 0, lock_left = 0;
   int q[$];
   int pw[4] = '{1, 2, 3, 4};
   int ent[4];
   bit pend = 0;
   bit match;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_login = 0; m_pmode = 0; m_locked = 0;
         m_err = 0; m_tries = 3; m_cnt = 0;
         pend = 0; q.delete();
         pw = '{1, 2, 3, 4};
      end else begin
         m_err = 0;
         if (pend) begin
            pend = 0;
            match = 1;
            for (int i = 0; i < 4; i++)
               if (ent[i] != pw[i]) match = 0;
            if (match) begin
               m_login = 1;
               m_tries = 3;
            end else begin
               m_err = 1;
               m_tries--;
               if (m_tries == 0) begin
                  m_locked = 1;
                  lock_left = 100;
               end
            end
         end else if (m_locked) begin
            lock_left--;
            if (lock_left == 0) begin
               m_locked = 0;
               m_tries = 3;
            end
         end else if (m_login) begin
            if (log_out) begin
               m_login = 0;
               if (pwd_res) m_pmode = 1;
            end
         end else if (clr) begin
            q.delete();
         end else if (enter && digit <= 9) begin
            q.push_back(int'(digit));
            if (q.size() == 4) begin
               for (int i = 0; i < 4; i++) begin
                  if (m_pmode) pw[i] = q[i];
                  else ent[i] = q[i];
               end
               if (m_pmode) m_pmode = 0;
               else pend = 1;
               q.delete();
            end
         end
         m_cnt = q.size();
      end
   end

   initial forever begin
      @(negedge clk);
      chk("cmp_log_in", log_in, m_login);
      chk("cmp_pwd_mode", pwd_mode, m_pmode);
      chk("cmp_locked", locked, m_locked);
      chk("cmp_err_pls", err_pls, m_err);
      chk("cmp_tries", tries, m_tries);
      chk("cmp_digit_cnt", dcnt, m_cnt);
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic key(input int d);
      enter = 1'b1;
      digit = 4'(d);
      idle(1);
      enter = 1'b0;
   endtask

   task automatic code(input int a, b, c, d);
      key(a); key(b); key(c); key(d);
   endtask

   task automatic logout(input logic pr);
      log_out = 1'b1;
      pwd_res = pr;
      idle(1);
      log_out = 1'b0;
      pwd_res = 1'b0;
   endtask

   int nlock;

   initial begin
      rst_n = 1'b0; digit = '0; enter = 1'b0;
      clr = 1'b0; log_out = 1'b0; pwd_res = 1'b0;
      idle(3);
      chk("rst_log_in", log_in, 0);
      chk("rst_tries", tries, 3);
      chk("rst_cnt", dcnt, 0);
      rst_n = 1'b1;
      idle(1);

      // default password, 2-cycle latency
      code(1, 2, 3, 4);
      chk("t1_latency1", log_in, 0);
      idle(1);
      chk("t1_login", log_in, 1);
      chk("t1_tries", tries, 3);
      logout(1'b0);
      chk("t1_logout", log_in, 0);

      // three wrong entries, then lockout
      for (int k = 0; k < 3; k++) begin
         code(1, 2, 3, 5);
         idle(1);
         chk("t2_err", err_pls, 1);
         chk("t2_tries", tries, 2 - k);
      end
      chk("t2_locked", locked, 1);
      nlock = 1;
      for (int d = 1; d <= 4; d++) begin
         key(d);
         if (locked) nlock++;
      end
      chk("t2_lock_cnt", dcnt, 0);
      while (locked && nlock < 200) begin
         idle(1);
         if (locked) nlock++;
      end
      chk("t2_lock_len", nlock, 100);
      chk("t2_tries_back", tries, 3);
      code(1, 2, 3, 4);
      idle(1);
      chk("t2_login", log_in, 1);
      logout(1'b0);

      // clear, and clear beating enter
      key(1); key(2);
      chk("t4_cnt2", dcnt, 2);
      clr = 1'b1; idle(1); clr = 1'b0;
      chk("t4_clr", dcnt, 0);
      key(1);
      clr = 1'b1; enter = 1'b1; digit = 4'd2;
      idle(1);
      clr = 1'b0; enter = 1'b0;
      chk("t4_clr_wins", dcnt, 0);
      code(1, 2, 3, 4);
      idle(1);
      chk("t4_login", log_in, 1);
      logout(1'b0);

      // non-BCD digit and stray Log_Out
      key(1); key(11);
      chk("t5_bad_digit", dcnt, 1);
      logout(1'b1);
      chk("t5_stray_cnt", dcnt, 1);
      chk("t5_stray_pm", pwd_mode, 0);
      key(2); key(3); key(4);
      idle(1);
      chk("t5_login", log_in, 1);

      // password change
      logout(1'b1);
      chk("t3_log_in", log_in, 0);
      chk("t3_pwd_mode", pwd_mode, 1);
      code(9, 8, 7, 6);
      chk("t3_pm_done", pwd_mode, 0);
      code(1, 2, 3, 4);
      idle(1);
      chk("t3_old_err", err_pls, 1);
      chk("t3_old_tries", tries, 2);
      code(9, 8, 7, 6);
      idle(1);
      chk("t3_new_login", log_in, 1);
      chk("t3_new_tries", tries, 3);

      // reset during password change
      logout(1'b1);
      key(5); key(6);
      chk("t6_cnt2", dcnt, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_pm", pwd_mode, 0);
      chk("t6_cnt", dcnt, 0);
      chk("t6_tries", tries, 3);
      chk("t6_log_in", log_in, 0);
      idle(1);
      rst_n = 1'b1;
      idle(1);
      code(1, 2, 3, 4);
      idle(1);
      chk("t6_login", log_in, 1);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
